// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants: rx FSM states, default frame
// geometry and the oversampling indices used for the per-bit majority vote.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

  // Three sample points straddling the bit centre (3, 4, 5 for OVERSAMPLE=8).
  localparam int SMP_FIRST_DEF  = OVERSAMPLE_DEF / 2 - 1;
  localparam int SMP_MID_DEF    = OVERSAMPLE_DEF / 2;
  localparam int SMP_LAST_DEF   = OVERSAMPLE_DEF / 2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Sample tick k (0..2) of the majority window for a given oversampling ratio.
  function automatic int sample_idx(input int oversample, input int k);
    return oversample / 2 - 1 + k;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Prescaler that emits a one-cycle tick every P clk cycles (P=0 acts as 1).
// A new P is picked up only at a wrap or a clear, so a running bit keeps its timing.
module baud_tick_gen #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  output logic                   tick_o
);

  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESC_WIDTH-1:0] period_q, period_d;
  logic [PRESC_WIDTH-1:0] last_cnt;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    last_cnt = (period_q == '0) ? '0 : period_q - PRESC_WIDTH'(1);
    tick_o   = (cnt_q == last_cnt);
    cnt_d    = cnt_q + PRESC_WIDTH'(1);
    period_d = period_q;
    if (clr || tick_o) begin
      cnt_d    = '0;
      period_d = presc_i;
    end
  end

  // NOTE: state flops use non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-FF synchronised line, OVERSAMPLE ticks per bit, 3-sample
// majority per bit, byte presented on a valid/ready handshake with overrun/frame flags.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRESC_WIDTH-1:0] preescalar_data_rate,
  input  logic                   rtx,
  input  logic                   ready_i,
  output logic [DATA_BITS-1:0]   data_o,
  output logic                   valid_o,
  output logic                   frame_error_o,
  output logic                   overrun_o
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] SMP_A    = SCW'(sample_idx(OVERSAMPLE, 0));
  localparam logic [SCW-1:0] SMP_B    = SCW'(sample_idx(OVERSAMPLE, 1));
  localparam logic [SCW-1:0] SMP_C    = SCW'(sample_idx(OVERSAMPLE, 2));
  localparam logic [SCW-1:0] SMP_END  = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BIT_LAST = BIW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BIW-1:0]       bit_idx_q, bit_idx_d;
  logic [2:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic start_edge, tick_clr, tick, bit_end, maj;

  assign start_edge = !sync2_q && prev_q;
  assign tick_clr   = (state_q == IDLE) && start_edge;
  assign bit_end    = tick && (sample_cnt_q == SMP_END);
  assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  baud_tick_gen #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (tick_clr),
    .presc_i (preescalar_data_rate),
    .tick_o  (tick)
  );

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    deliver_d    = 1'b0;
    ferr_d       = 1'b0;
    ovr_d        = 1'b0;
    data_d       = data_q;
    valid_d      = valid_q;

    if (state_q != IDLE && tick) begin
      if (sample_cnt_q == SMP_A) smp_d[0] = sync2_q;
      if (sample_cnt_q == SMP_B) smp_d[1] = sync2_q;
      if (sample_cnt_q == SMP_C) smp_d[2] = sync2_q;
      sample_cnt_d = bit_end ? '0 : sample_cnt_q + SCW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d      = START;
          sample_cnt_d = '0;
          bit_idx_d    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = maj ? IDLE : DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIW'(1);
          if (bit_idx_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          deliver_d = maj;
          ferr_d    = !maj;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance and a new delivery can coincide; the delivery then wins.
    if (valid_q && ready_i) valid_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      deliver_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      sync1_q      <= rtx;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      deliver_q    <= deliver_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign frame_error_o = ferr_q;
  assign overrun_o     = ovr_q;

endmodule
